instr_fetch_sequencer: RTL and testbench
========================================

Name: instr_fetch_sequencer

Overview:
Front-end fetch controller for the 8-bit CPU. It reads opcode and operand bytes from instruction memory at the program counter value and presents complete instructions to decode with a valid/ready handshake. It drives the program counter's pc_enable and pc_next, covering both sequential increment and execute-stage redirects (jumps/branches). It sits between the program counter register, the instruction memory port and the decoder.

Parameters:
ADDR_W, 8, program counter / memory address width
DATA_W, 8, instruction memory byte width
LONG_PREFIX, 2'b11, value of opcode[7:6] marking a two-byte instruction (opcode + operand)

Ports:
clk  input  1  clock, rising-edge
reset  input  1  asynchronous, active-high
run  input  1  fetch permitted; low = stop issuing new memory requests
pc  input  ADDR_W  current program counter value
pc_enable  output  1  single-cycle strobe: PC loads pc_next at next rising edge
pc_next  output  ADDR_W  value for PC to load
mem_req  output  1  instruction memory read request
mem_addr  output  ADDR_W  read address (combinationally equal to pc)
mem_ready  input  1  memory response; mem_rdata valid in the same cycle
mem_rdata  input  DATA_W  read data
instr_valid  output  1  instruction available to decode
instr_opcode  output  DATA_W  fetched opcode
instr_operand  output  DATA_W  fetched operand (8'h00 for one-byte instructions)
instr_long  output  1  instruction has an operand byte
instr_ready  input  1  decode accepts the instruction
redirect_valid  input  1  single-cycle redirect request from execute
redirect_target  input  ADDR_W  redirect destination

Behaviour:
- Reset is asynchronous and active-high; clock is clk. During and after reset: state=IDLE, mem_req=0, pc_enable=0, instr_valid=0, instr_long=0, instr_opcode=0, instr_operand=0, redirect_pending=0. pc_next defaults to pc+1 (8'h01 while PC is 0).
- States: IDLE, FETCH_OP, FETCH_ARG, PRESENT.
- IDLE: when run=1, go to FETCH_OP on the next edge.
- FETCH_OP / FETCH_ARG: mem_req=1, mem_addr=pc.
  - Handshake completes in a cycle with mem_req=1 and mem_ready=1.
  - mem_req and the address (the PC) stay stable until completion. The PC is never changed while a request is outstanding.
- On completion in FETCH_OP with no pending redirect:
  - Latch opcode; assert pc_enable=1 with pc_next=pc+1 in the same cycle.
  - If opcode[7:6]==LONG_PREFIX, go to FETCH_ARG. Otherwise set operand=0, long=0 and go to PRESENT.
- On completion in FETCH_ARG with no pending redirect: latch operand, long=1, pc_enable with pc+1, go to PRESENT.
- Address arithmetic is modulo 2^ADDR_W: pc 8'hFF increments to 8'h00. A long opcode at 8'hFF takes its operand from 8'h00.
- PRESENT: instr_valid=1 with the registered fields held stable until instr_ready=1. On acceptance, go to FETCH_OP if run=1, else IDLE. Latency is at least one cycle between acceptance and the next mem_req.
- redirect_valid has priority over everything except an outstanding memory handshake:
  - In IDLE or PRESENT: pc_enable=1, pc_next=redirect_target that cycle. instr_valid drops next cycle and the presented instruction is discarded even if instr_ready=1 the same cycle. Next state is FETCH_OP if run=1, else IDLE.
  - In FETCH_OP/FETCH_ARG with mem_ready=1 the same cycle: the returned data is discarded, pc_enable=1 with pc_next=redirect_target, next state FETCH_OP (or IDLE if run=0).
  - In FETCH_OP/FETCH_ARG with mem_ready=0: store the target and set redirect_pending. mem_req stays asserted at the old address. On completion, the data is discarded, pc_enable=1 with pc_next=stored target, pending clears, next state FETCH_OP. A later redirect while pending overwrites the stored target (last wins).
- run=0 never aborts an outstanding request. It takes effect only at IDLE entry decisions.
- pc_enable is never asserted for more than one cycle per event. pc_next is meaningful only when pc_enable=1.
- Reset mid-request drops mem_req immediately (asynchronous) and discards any partial instruction.

Test Plan:
- Sequential short ops: memory[0..2]=8'h01,8'h02,8'h03, mem_ready always 1, instr_ready=1 -> instructions 01,02,03 with long=0 and operand=00; pc_enable pulses with pc_next 01,02,03.
- Long op: memory[4]=8'hC5, memory[5]=8'h20 -> one instruction opcode C5, operand 20, long=1; two pc_enable pulses (05, 06); single instr_valid.
- Wrap: pc=8'hFF, memory[FF]=8'hC0, memory[00]=8'h7A -> operand 7A, pc_next sequence 00 then 01.
- Backpressure: instr_ready=0 for 5 cycles in PRESENT -> instr_valid and fields stable, no mem_req, no pc_enable until acceptance.
- Redirect during wait: mem_ready held low 3 cycles, redirect_valid pulse with target 8'h40 in cycle 1 -> mem_addr unchanged until ready; returned byte discarded; one pc_enable with pc_next=40; next request at address 40.
- Redirect vs present plus reset: redirect to 8'h10 in the same cycle as instr_ready=1 in PRESENT -> instruction not counted, pc_next=10. Then assert reset mid-FETCH_ARG -> mem_req=0 and instr_valid=0 immediately; after release with run=1, fetch restarts from pc=00.

Source files
------------

// File: rtl/instr_fetch_sequencer.sv
// instr_fetch_sequencer: fetches opcode/operand bytes at the PC and hands complete instructions to decode
// Ports:
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   run                 permits new fetches; sampled only when leaving IDLE/PRESENT or after a redirect
//   pc                  current program counter value
//   pc_enable, pc_next  one-cycle strobe and value for the PC register to load
//   mem_req, mem_addr   instruction memory read request at the PC
//   mem_ready           memory response, mem_rdata valid in the same cycle
//   instr_*             instruction presented to decode (valid/ready handshake)
//   redirect_valid      one-cycle jump/branch request from execute, redirect_target its destination
module instr_fetch_sequencer #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 8,
   parameter logic [1:0] LONG_PREFIX = 2'b11
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
   input  logic [ADDR_W-1:0] pc,
   output logic              pc_enable,
   output logic [ADDR_W-1:0] pc_next,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              instr_valid,
   output logic [DATA_W-1:0] instr_opcode,
   output logic [DATA_W-1:0] instr_operand,
   output logic              instr_long,
   input  logic              instr_ready,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_target
);
   typedef enum logic [1:0] {IDLE, FETCH_OP, FETCH_ARG, PRESENT} state_t;
   state_t state;
   logic redirect_pending;
   logic [ADDR_W-1:0] redirect_store;
   logic [ADDR_W-1:0] pc_inc;
   logic fetching;
   logic done;
   assign fetching = (state == FETCH_OP) || (state == FETCH_ARG);
   assign done = fetching && mem_ready;
   assign pc_inc = pc + ADDR_W'(1);
   assign mem_req = fetching;
   assign mem_addr = pc;
   assign instr_valid = (state == PRESENT);
   // an outstanding request blocks redirects, so the PC only moves on completion or outside a fetch
   assign pc_enable = done || (redirect_valid && !fetching);
   assign pc_next = !pc_enable ? pc_inc
                  : redirect_valid ? redirect_target
                  : redirect_pending ? redirect_store
                  : pc_inc;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         redirect_pending <= 1'b0;
         redirect_store <= '0;
         instr_opcode <= '0;
         instr_operand <= '0;
         instr_long <= 1'b0;
      end else begin
         case (state)
            IDLE: state <= run ? FETCH_OP : IDLE;
            PRESENT: if (redirect_valid || instr_ready) state <= run ? FETCH_OP : IDLE;
            default: begin
               if (mem_ready) begin
                  redirect_pending <= 1'b0;
                  // a redirect arriving with the data, or one parked earlier, discards the byte
                  if (redirect_valid) state <= run ? FETCH_OP : IDLE;
                  else if (redirect_pending) state <= FETCH_OP;
                  else if (state == FETCH_OP) begin
                     instr_opcode <= mem_rdata;
                     if (mem_rdata[DATA_W-1 -: 2] == LONG_PREFIX) state <= FETCH_ARG;
                     else begin
                        instr_operand <= '0;
                        instr_long <= 1'b0;
                        state <= PRESENT;
                     end
                  end else begin
                     instr_operand <= mem_rdata;
                     instr_long <= 1'b1;
                     state <= PRESENT;
                  end
               end else if (redirect_valid) begin
                  redirect_pending <= 1'b1;
                  redirect_store <= redirect_target;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_instr_fetch_sequencer.sv
// tb_instr_fetch_sequencer: directed and random checks of the fetch sequencer against an instruction-stream model
module tb_instr_fetch_sequencer;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic run = 1'b0;
   logic mem_ready = 1'b0;
   logic instr_ready = 1'b0;
   logic redirect_valid = 1'b0;
   logic [7:0] redirect_target = 8'h00;
   logic [7:0] pc, pc_next, mem_addr, mem_rdata, instr_opcode, instr_operand;
   logic pc_enable, mem_req, instr_valid, instr_long;
   logic [7:0] mem [256];
   int total = 0;
   int passed = 0;
   int acc = 0;
   int n;
   logic [7:0] exp_start, pend_tgt, prev_addr, prev_op, prev_arg;
   logic pend, prev_wait, prev_hold, prev_long;
   logic [7:0] pcq [$];
   logic [16:0] got [$];

   instr_fetch_sequencer dut (
      .clk(clk), .reset(reset), .run(run), .pc(pc),
      .pc_enable(pc_enable), .pc_next(pc_next),
      .mem_req(mem_req), .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .instr_valid(instr_valid), .instr_opcode(instr_opcode), .instr_operand(instr_operand),
      .instr_long(instr_long), .instr_ready(instr_ready),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target)
   );

   always #5 clk = ~clk;
   assign mem_rdata = mem[mem_addr];
   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc <= 8'h00;
      else if (pc_enable) pc <= pc_next;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) begin
         passed++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      exp_start = 8'h00;
      pend = 1'b0;
      prev_wait = 1'b0;
      prev_hold = 1'b0;
   endtask

   // instruction-stream model: tracks where the next instruction starts and which redirect is owed
   task automatic check_cycle();
      logic [7:0] op, a1, nx;
      logic lg;
      nx = pc + 8'd1;
      chk("mem_addr", mem_addr, pc);
      if (prev_wait) begin
         chk("req_hold", mem_req, 1);
         chk("addr_hold", mem_addr, prev_addr);
      end
      if (prev_hold) begin
         chk("valid_hold", instr_valid, 1);
         chk("op_hold", instr_opcode, prev_op);
         chk("arg_hold", instr_operand, prev_arg);
         chk("long_hold", instr_long, prev_long);
      end
      if (instr_valid) chk("req_in_present", mem_req, 0);
      if (mem_req && !mem_ready) begin
         chk("pce_wait", pc_enable, 0);
         if (redirect_valid) begin
            pend = 1'b1;
            pend_tgt = redirect_target;
         end
      end else if (redirect_valid) begin
         chk("pce_redir", pc_enable, 1);
         chk("pc_next_redir", pc_next, redirect_target);
         exp_start = redirect_target;
         pend = 1'b0;
      end else if (mem_req) begin
         chk("pce_done", pc_enable, 1);
         if (pend) begin
            chk("pc_next_pend", pc_next, pend_tgt);
            exp_start = pend_tgt;
            pend = 1'b0;
         end else chk("pc_next_inc", pc_next, nx);
      end else chk("pce_quiet", pc_enable, 0);
      if (pc_enable) pcq.push_back(pc_next);
      if (instr_valid && instr_ready && !redirect_valid) begin
         op = mem[exp_start];
         a1 = exp_start + 8'd1;
         lg = (op[7:6] == 2'b11);
         chk("opcode", instr_opcode, op);
         chk("long", instr_long, lg);
         chk("operand", instr_operand, lg ? mem[a1] : 8'h00);
         got.push_back({instr_long, instr_opcode, instr_operand});
         exp_start = exp_start + (lg ? 8'd2 : 8'd1);
         acc++;
      end
      prev_wait = mem_req && !mem_ready;
      prev_addr = mem_addr;
      prev_hold = instr_valid && !instr_ready && !redirect_valid;
      prev_op = instr_opcode;
      prev_arg = instr_operand;
      prev_long = instr_long;
   endtask

   task automatic tick();
      #4;
      if (reset) model_reset();
      else check_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [16:0] e_seq [5];
      e_seq = '{17'h00100, 17'h00200, 17'h00300, 17'h00400, 17'h1C520};
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      mem[0] = 8'h01; mem[1] = 8'h02; mem[2] = 8'h03; mem[3] = 8'h04; mem[4] = 8'hC5; mem[5] = 8'h20;
      @(posedge clk);
      #1;
      tick();
      tick();
      #4;
      chk("rst_mem_req", mem_req, 0);
      chk("rst_pc_enable", pc_enable, 0);
      chk("rst_instr_valid", instr_valid, 0);
      chk("rst_instr_long", instr_long, 0);
      chk("rst_opcode", instr_opcode, 0);
      chk("rst_operand", instr_operand, 0);
      chk("rst_pc_next", pc_next, 8'h01);
      @(posedge clk);
      #1;
      // sequential short ops followed by one long op
      reset = 1'b0; run = 1'b1; mem_ready = 1'b1; instr_ready = 1'b1;
      got.delete(); pcq.delete();
      for (int i = 0; i < 60 && got.size() < 5; i++) tick();
      chk("seq_count", got.size() >= 5, 1);
      for (int i = 0; i < 5; i++) chk("seq_instr", got[i], e_seq[i]);
      for (int i = 0; i < 6; i++) chk("seq_pc_next", pcq[i], i + 1);
      // wrap from FF plus backpressure
      reset = 1'b1; run = 1'b0;
      tick();
      reset = 1'b0;
      mem[8'hFF] = 8'hC0; mem[8'h00] = 8'h7A;
      tick();
      got.delete(); pcq.delete();
      redirect_valid = 1'b1; redirect_target = 8'hFF;
      tick();
      redirect_valid = 1'b0; run = 1'b1; instr_ready = 1'b0; mem_ready = 1'b1;
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      chk("bp_reach", instr_valid, 1);
      repeat (5) tick();
      run = 1'b0; instr_ready = 1'b1;
      tick();
      chk("wrap_count", got.size(), 1);
      chk("wrap_instr", got[0], 17'h1C07A);
      chk("wrap_pcq_size", pcq.size(), 3);
      chk("wrap_pc0", pcq[0], 8'hFF);
      chk("wrap_pc1", pcq[1], 8'h00);
      chk("wrap_pc2", pcq[2], 8'h01);
      // redirect parked behind a slow memory response
      mem[8'h40] = 8'h11;
      got.delete(); pcq.delete();
      run = 1'b1; mem_ready = 1'b0; instr_ready = 1'b1;
      tick();
      tick();
      redirect_valid = 1'b1; redirect_target = 8'h40;
      tick();
      redirect_valid = 1'b0;
      tick();
      mem_ready = 1'b1;
      tick();
      for (int i = 0; i < 20 && got.size() < 1; i++) tick();
      chk("pend_pc_next", pcq[0], 8'h40);
      chk("pend_instr", got[0], 17'h01100);
      // redirect beats acceptance, then reset in the middle of an operand fetch
      mem[8'h10] = 8'hC3; mem[8'h11] = 8'h55;
      instr_ready = 1'b0;
      for (int i = 0; i < 20 && !instr_valid; i++) tick();
      chk("rp_reach", instr_valid, 1);
      n = got.size();
      redirect_valid = 1'b1; redirect_target = 8'h10; instr_ready = 1'b1;
      tick();
      redirect_valid = 1'b0; instr_ready = 1'b0;
      chk("rp_discard", got.size(), n);
      chk("rp_pc", pc, 8'h10);
      mem_ready = 1'b1;
      tick();
      mem_ready = 1'b0;
      #2;
      chk("arg_req", mem_req, 1);
      chk("arg_addr", mem_addr, 8'h11);
      reset = 1'b1;
      #1;
      chk("async_mem_req", mem_req, 0);
      chk("async_instr_valid", instr_valid, 0);
      @(posedge clk);
      #1;
      tick();
      reset = 1'b0; run = 1'b1; mem_ready = 1'b1; instr_ready = 1'b1;
      got.delete(); pcq.delete();
      for (int i = 0; i < 20 && got.size() < 1; i++) tick();
      chk("restart_instr", got[0], {1'b0, mem[8'h00], 8'h00});
      chk("restart_pc_next", pcq[0], 8'h01);
      // random traffic against the stream model
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
      acc = 0;
      for (int i = 0; i < 3000; i++) begin
         run = ($urandom % 8) != 0;
         mem_ready = ($urandom % 3) != 0;
         instr_ready = ($urandom % 2) != 0;
         redirect_valid = ($urandom % 16) == 0;
         redirect_target = 8'($urandom);
         tick();
      end
      chk("random_progress", acc > 100, 1);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
